// File: rtl/fetch_unit.sv
// IF-stage fetch engine: owns the PC, issues single outstanding IM reads and presents words to IF/ID.
// Define FETCH_ADDR_EXC_EN to add fetch address checking and the F_exc (AdEL) output.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_vld,
  input  logic [31:0] redirect_pc,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_valid,
  input  logic [31:0] im_rdata,
  output logic [31:0] F_ins,
  output logic [31:0] F_PC,
  output logic        F_valid
`ifdef FETCH_ADDR_EXC_EN
  ,
  output logic        F_exc
`endif
);

  typedef enum logic [1:0] {StReq, StWait, StValid, StDrain} state_e;

  state_e      r_state;
  logic [31:0] r_pc;
  logic [31:0] w_pc_inc;
  logic        w_req_point;
  logic        w_addr_ok;

  assign w_pc_inc    = r_pc + 32'd4;
  assign im_addr     = (r_state == StValid) ? w_pc_inc : r_pc;
  assign w_req_point = reset && !redirect_vld &&
                       ((r_state == StReq) || ((r_state == StValid) && !stall));

`ifdef FETCH_ADDR_EXC_EN
  localparam logic [32:0] ImBytes = 33'(IM_WORDS) << 2;
  logic [31:0] w_off;
  assign w_off     = im_addr - IM_BASE;
  assign w_addr_ok = (im_addr[1:0] == 2'b00) && (im_addr >= IM_BASE) && ({1'b0, w_off} < ImBytes);
`else
  assign w_addr_ok = 1'b1;
`endif

  assign im_req = w_req_point && w_addr_ok;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= StReq;
      r_pc    <= RESET_PC;
      F_ins   <= '0;
      F_PC    <= RESET_PC;
      F_valid <= 1'b0;
    end else if (redirect_vld) begin
      r_pc    <= redirect_pc;
      F_valid <= 1'b0;
      // A response landing with the redirect retires the outstanding read, so no drain is needed.
      unique case (r_state)
        StWait, StDrain: r_state <= im_valid ? StReq : StDrain;
        default:         r_state <= StReq;
      endcase
    end else begin
      unique case (r_state)
        StReq: begin
          if (w_addr_ok) begin
            r_state <= StWait;
          end else begin
            F_ins   <= '0;
            F_PC    <= im_addr;
            F_valid <= 1'b1;
            r_state <= StValid;
          end
        end
        StWait: begin
          if (im_valid) begin
            F_ins   <= im_rdata;
            F_PC    <= r_pc;
            F_valid <= 1'b1;
            r_state <= StValid;
          end
        end
        StValid: begin
          if (!stall) begin
            r_pc <= w_pc_inc;
            if (w_addr_ok) begin
              F_valid <= 1'b0;
              r_state <= StWait;
            end else begin
              F_ins   <= '0;
              F_PC    <= im_addr;
              F_valid <= 1'b1;
              r_state <= StValid;
            end
          end
        end
        StDrain: begin
          if (im_valid) begin
            r_state <= StReq;
          end
        end
      endcase
    end
  end

`ifdef FETCH_ADDR_EXC_EN
  always_ff @(posedge clk) begin
    if (!reset || redirect_vld) begin
      F_exc <= 1'b0;
    end else if (w_req_point && !w_addr_ok) begin
      F_exc <= 1'b1;
    end else if ((r_state == StValid) && !stall) begin
      F_exc <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural IM with programmable latency plus a PC scoreboard.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_vld = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_valid;
  logic [31:0] im_rdata;
  logic [31:0] F_ins;
  logic [31:0] F_PC;
  logic        F_valid;
`ifdef FETCH_ADDR_EXC_EN
  logic        F_exc;
`endif

  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  int unsigned im_lat = 1;
  logic        im_pend = 1'b0;
  int unsigned im_cnt = 0;
  logic [31:0] im_addr_q = '0;
  logic        mon_fv_prev = 1'b0;

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect_vld(redirect_vld),
    .redirect_pc (redirect_pc),
    .im_req      (im_req),
    .im_addr     (im_addr),
    .im_valid    (im_valid),
    .im_rdata    (im_rdata),
    .F_ins       (F_ins),
    .F_PC        (F_PC),
    .F_valid     (F_valid)
`ifdef FETCH_ADDR_EXC_EN
    ,
    .F_exc       (F_exc)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] im_word(input logic [31:0] a);
    return 32'h2408_0001 + (a - 32'h0000_3000);
  endfunction

  // IM model: one response im_lat cycles after each request; dropped when reset is low.
  always @(posedge clk) begin
    if (!reset) begin
      im_pend <= 1'b0;
    end else if (im_req) begin
      im_pend   <= 1'b1;
      im_cnt    <= im_lat;
      im_addr_q <= im_addr;
    end else if (im_pend && im_cnt > 1) begin
      im_cnt <= im_cnt - 1;
    end else begin
      im_pend <= 1'b0;
    end
  end
  assign im_valid = im_pend && (im_cnt == 1);
  assign im_rdata = im_word(im_addr_q);

  // Scoreboard: every newly presented word must match the oldest expected PC.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && F_valid === 1'b1 && mon_fv_prev !== 1'b1
`ifdef FETCH_ADDR_EXC_EN
          && F_exc !== 1'b1
`endif
         ) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got word pc=%h ins=%h, want none", F_PC, F_ins);
        end else begin
          e = exp_q.pop_front();
          if (F_PC !== e || F_ins !== im_word(e)) begin
            n_fail++;
            $display("FAIL sb_word: got pc=%h ins=%h, want pc=%h ins=%h", F_PC, F_ins, e, im_word(e));
          end
        end
      end
      mon_fv_prev = F_valid;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (im_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #2;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; stall = 1'b0; redirect_vld = 1'b0; im_lat = 1;
    tick(); tick();
    n_tests++;
    if (F_valid !== 1'b0 || F_PC !== 32'h3000 || F_ins !== 32'h0 || im_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b pc=%h ins=%h req=%b, want 0 3000 0 0",
               F_valid, F_PC, F_ins, im_req);
    end
    reset = 1'b1; #1;
    n_tests++;
    if (im_req !== 1'b1 || im_addr !== 32'h3000) begin
      n_fail++;
      $display("FAIL first_req: got req=%b addr=%h, want 1 3000", im_req, im_addr);
    end
    exp_q.push_back(32'h3000);
    tick();
    n_tests++;
    if (F_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL first_wait: got F_valid=%b want 0", F_valid);
    end
    tick();
    n_tests++;
    if (F_valid !== 1'b1 || F_PC !== 32'h3000 || F_ins !== 32'h2408_0001) begin
      n_fail++;
      $display("FAIL first_word: got v=%b pc=%h ins=%h, want 1 3000 24080001", F_valid, F_PC, F_ins);
    end
  endtask

  task automatic test_stall();
    stall = 1'b1; #1;
    n_tests++;
    if (im_req !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_req0: got im_req=%b want 0", im_req);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if (F_valid !== 1'b1 || F_PC !== 32'h3000 || F_ins !== 32'h2408_0001 || im_req !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold: got v=%b pc=%h ins=%h req=%b, want 1 3000 24080001 0",
                 F_valid, F_PC, F_ins, im_req);
      end
    end
    stall = 1'b0; #1;
    n_tests++;
    if (im_req !== 1'b1 || im_addr !== 32'h3004) begin
      n_fail++;
      $display("FAIL stall_release: got req=%b addr=%h, want 1 3004", im_req, im_addr);
    end
    exp_q.push_back(32'h3004);
    tick(); tick();
    n_tests++;
    if (F_valid !== 1'b1 || F_PC !== 32'h3004) begin
      n_fail++;
      $display("FAIL stall_next_word: got v=%b pc=%h, want 1 3004", F_valid, F_PC);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_addr;
    int n;
    exp_addr = 32'h3008;
    for (int k = 0; k < 6; k++) begin
      im_lat = (k % 2 == 1) ? 2 : 1;
      #1;
      n_tests++;
      if (im_req !== 1'b1 || im_addr !== exp_addr) begin
        n_fail++;
        $display("FAIL b2b_req: got req=%b addr=%h, want 1 %h", im_req, im_addr, exp_addr);
      end
      exp_q.push_back(exp_addr);
      n = 0;
      do begin
        tick();
        n++;
      end while (F_valid !== 1'b1 && n < 20);
      n_tests++;
      if (n != int'(im_lat) + 1) begin
        n_fail++;
        $display("FAIL b2b_latency: got %0d cycles, want %0d", n, im_lat + 1);
      end
      exp_addr = exp_addr + 32'd4;
    end
  endtask

  task automatic test_redirect_wait();
    bit ok;
    im_lat = 3; #1;
    tick();
    redirect_vld = 1'b1; redirect_pc = 32'h3100; #1;
    n_tests++;
    if (im_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rdw_req_during_redirect: got %b want 0", im_req);
    end
    tick();
    redirect_vld = 1'b0; im_lat = 1; #1;
    n_tests++;
    if (F_valid !== 1'b0 || im_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rdw_drain: got v=%b req=%b, want 0 0", F_valid, im_req);
    end
    wait_req(ok);
    n_tests++;
    if (!ok || im_addr !== 32'h3100) begin
      n_fail++;
      $display("FAIL rdw_new_req: got ok=%b addr=%h, want 1 3100", ok, im_addr);
    end
    exp_q.push_back(32'h3100);
    tick(); tick();
    n_tests++;
    if (F_valid !== 1'b1 || F_PC !== 32'h3100) begin
      n_fail++;
      $display("FAIL rdw_word: got v=%b pc=%h, want 1 3100", F_valid, F_PC);
    end
  endtask

  task automatic test_redirect_same_cycle();
    im_lat = 2; #1;
    tick(); tick();
    redirect_vld = 1'b1; redirect_pc = 32'h3200; #1;
    n_tests++;
    if (im_valid !== 1'b1 || im_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rsc_collide: got im_valid=%b req=%b, want 1 0", im_valid, im_req);
    end
    tick();
    redirect_vld = 1'b0; im_lat = 1; #1;
    n_tests++;
    if (F_valid !== 1'b0 || im_req !== 1'b1 || im_addr !== 32'h3200) begin
      n_fail++;
      $display("FAIL rsc_req: got v=%b req=%b addr=%h, want 0 1 3200", F_valid, im_req, im_addr);
    end
    exp_q.push_back(32'h3200);
    tick();
    n_tests++;
    if (im_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rsc_single_req: got %b want 0", im_req);
    end
    tick();
    // Redirect against a consumable word: redirect wins, no pc+4 request.
    redirect_vld = 1'b1; redirect_pc = 32'h3300; #1;
    n_tests++;
    if (im_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rcons_no_inc: got im_req=%b want 0", im_req);
    end
    tick();
    redirect_vld = 1'b0; #1;
    n_tests++;
    if (F_valid !== 1'b0 || im_req !== 1'b1 || im_addr !== 32'h3300) begin
      n_fail++;
      $display("FAIL rcons_req: got v=%b req=%b addr=%h, want 0 1 3300", F_valid, im_req, im_addr);
    end
    exp_q.push_back(32'h3300);
    tick();
    n_tests++;
    if (im_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rcons_single_req: got %b want 0", im_req);
    end
    tick();
    n_tests++;
    if (F_valid !== 1'b1 || F_PC !== 32'h3300) begin
      n_fail++;
      $display("FAIL rcons_word: got v=%b pc=%h, want 1 3300", F_valid, F_PC);
    end
  endtask

  task automatic test_reset_mid_wait();
    im_lat = 3; #1;
    tick();
    reset = 1'b0; #1;
    n_tests++;
    if (im_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rmw_req_in_reset: got %b want 0", im_req);
    end
    tick();
    n_tests++;
    if (F_valid !== 1'b0 || F_PC !== 32'h3000 || F_ins !== 32'h0) begin
      n_fail++;
      $display("FAIL rmw_state: got v=%b pc=%h ins=%h, want 0 3000 0", F_valid, F_PC, F_ins);
    end
    reset = 1'b1; im_lat = 1; #1;
    n_tests++;
    if (im_req !== 1'b1 || im_addr !== 32'h3000) begin
      n_fail++;
      $display("FAIL rmw_first_req: got req=%b addr=%h, want 1 3000", im_req, im_addr);
    end
    exp_q.push_back(32'h3000);
    tick(); tick();
    n_tests++;
    if (F_valid !== 1'b1 || F_PC !== 32'h3000 || F_ins !== 32'h2408_0001) begin
      n_fail++;
      $display("FAIL rmw_word: got v=%b pc=%h ins=%h, want 1 3000 24080001", F_valid, F_PC, F_ins);
    end
  endtask

`ifdef FETCH_ADDR_EXC_EN
  task automatic test_exc();
    logic [31:0] bad_pc[2];
    bad_pc[0] = 32'h3002;
    bad_pc[1] = 32'h7000;
    for (int i = 0; i < 2; i++) begin
      redirect_vld = 1'b1; redirect_pc = bad_pc[i];
      tick();
      redirect_vld = 1'b0; #1;
      n_tests++;
      if (im_req !== 1'b0 || F_exc !== 1'b0) begin
        n_fail++;
        $display("FAIL exc_no_req: got req=%b exc=%b, want 0 0", im_req, F_exc);
      end
      tick();
      n_tests++;
      if (F_valid !== 1'b1 || F_exc !== 1'b1 || F_ins !== 32'h0 || F_PC !== bad_pc[i]) begin
        n_fail++;
        $display("FAIL exc_word: got v=%b exc=%b ins=%h pc=%h, want 1 1 0 %h",
                 F_valid, F_exc, F_ins, F_PC, bad_pc[i]);
      end
    end
    redirect_vld = 1'b1; redirect_pc = 32'h3000;
    tick();
    redirect_vld = 1'b0; #1;
    n_tests++;
    if (im_req !== 1'b1 || im_addr !== 32'h3000 || F_exc !== 1'b0) begin
      n_fail++;
      $display("FAIL exc_recover: got req=%b addr=%h exc=%b, want 1 3000 0", im_req, im_addr, F_exc);
    end
    exp_q.push_back(32'h3000);
    tick(); tick();
  endtask
`else
  task automatic test_wrap();
    redirect_vld = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_vld = 1'b0; #1;
    n_tests++;
    if (im_req !== 1'b1 || im_addr !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_req_top: got req=%b addr=%h, want 1 fffffffc", im_req, im_addr);
    end
    exp_q.push_back(32'hFFFF_FFFC);
    tick(); tick(); #1;
    n_tests++;
    if (im_req !== 1'b1 || im_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_req_zero: got req=%b addr=%h, want 1 00000000", im_req, im_addr);
    end
    exp_q.push_back(32'h0);
    tick(); tick();
    n_tests++;
    if (F_valid !== 1'b1 || F_PC !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_word: got v=%b pc=%h, want 1 00000000", F_valid, F_PC);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stall();
    test_back_to_back();
    test_redirect_wait();
    test_redirect_same_cycle();
    test_reset_mid_wait();
`ifdef FETCH_ADDR_EXC_EN
    test_exc();
`else
    test_wrap();
`endif
    stall = 1'b1;
    tick(); tick();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drained: got %0d pending words, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
